msg_scroller: RTL and testbench

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/msg_scroller_pkg.sv | 21 ++
 rtl/msg_rom.sv | 11 +
 rtl/msg_scroller.sv | 155 +++++++++++++++
 tb/tb_msg_scroller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_scroller_pkg.sv
// Shared constants for the message scroller: the 16-digit message table,
// the scroller state encoding and a table lookup helper.
package msg_scroller_pkg;

  localparam int MSG_MAX = 16;

  // Entry 0 sits in the top nibble so the literal reads in message order.
  localparam logic [4*MSG_MAX-1:0] MSG_TABLE = 64'hAAC0_FFEE_A15A_900D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Entry idx lives at bit offset 4*(15-idx); 15-idx is the bitwise inverse of a 4-bit idx.
  function automatic logic [3:0] msg_digit(input logic [3:0] idx);
    return MSG_TABLE[{~idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational message lookup: table index in, hex digit out.
module msg_rom
  import msg_scroller_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [3:0] digit_o
);

  assign digit_o = msg_digit(idx_i);

endmodule

// File: rtl/msg_scroller.sv
// Scrolling window over a fixed hex message, with auto-scroll, manual step and
// direction control. Define MSG_SCROLLER_PAUSE_EN to hold the window after each wrap.
//
// Handshake: step is a single-cycle request sampled on the rising clock edge; there is
// no ready, every step is accepted in IDLE and RUN and dropped in PAUSE.
// state_o is a debug view of the FSM state (msg_scroller_pkg::state_e encoding).
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 25000000,
  parameter int PAUSE_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       step,
  output logic [NUM_DIGITS*4-1:0]    digits_o,
  output logic [$clog2(MSG_LEN)-1:0] pos_o,
  output logic                       wrap_o,
  output logic [1:0]                 state_o
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

`ifdef MSG_SCROLLER_PAUSE_EN
  localparam logic PAUSE_ON = 1'b1;
`else
  localparam logic PAUSE_ON = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic          move;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    tick    = 1'b0;
    move    = 1'b0;

    // The prescaler also paces the hold in PAUSE, which is measured in ticks.
    if (state_q != ST_IDLE) begin
      if (presc_q == TW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        move = step;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        move = tick | step;
        if (!en) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        // The final hold tick is also the first scroll move after the pause.
        if (tick) begin
          if (pcnt_q == CW'(PAUSE_TICKS - 1)) begin
            pcnt_d  = '0;
            move    = 1'b1;
            state_d = ST_RUN;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        if (!en) begin
          move    = 1'b0;
          pcnt_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (move) begin
      if (dir) begin
        if (pos_q == '0) begin
          pos_d  = PW'(MSG_LEN - 1);
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end else begin
        if (pos_q == PW'(MSG_LEN - 1)) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
    end

    if (PAUSE_ON && state_q == ST_RUN && en && wrap_d) begin
      state_d = ST_PAUSE;
      presc_d = '0;
      pcnt_d  = '0;
    end

    if (state_d == ST_IDLE) begin
      presc_d = '0;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      pcnt_q  <= '0;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end
  end

  // Digit k shows entry (pos + k) mod MSG_LEN; k never exceeds MSG_LEN-1, so one subtract suffices.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [4:0] sum;
    logic [3:0] idx;
    assign sum = 5'(pos_q) + 5'(k);
    assign idx = 4'((sum >= 5'(MSG_LEN)) ? (sum - 5'(MSG_LEN)) : sum);

    msg_rom u_rom (
      .idx_i   (idx),
      .digit_o (digits_o[(NUM_DIGITS-1-k)*4 +: 4])
    );
  end

  assign pos_o   = pos_q;
  assign wrap_o  = wrap_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: per-cycle comparison against a behavioural
// model, a move scoreboard, and hand-computed literal checkpoints.
module tb_msg_scroller;
  import msg_scroller_pkg::*;

  localparam int MSG_LEN     = 16;
  localparam int NUM_DIGITS  = 4;
  localparam int TICK_DIV    = 4;
  localparam int PAUSE_TICKS = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        dir;
  logic        step;
  logic [15:0] digits_o;
  logic [3:0]  pos_o;
  logic        wrap_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  // Model state
  int m_mode = 0;
  int m_cnt  = 0;
  int m_pcnt = 0;
  int m_pos  = 0;
  int m_wrap = 0;

  int msg_tbl[16] = '{10, 10, 12, 0, 15, 15, 14, 14, 10, 1, 5, 10, 9, 0, 0, 13};

  msg_scroller #(
    .MSG_LEN     (MSG_LEN),
    .NUM_DIGITS  (NUM_DIGITS),
    .TICK_DIV    (TICK_DIV),
    .PAUSE_TICKS (PAUSE_TICKS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .step     (step),
    .digits_o (digits_o),
    .pos_o    (pos_o),
    .wrap_o   (wrap_o),
    .state_o  (state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] window(input int p);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < NUM_DIGITS; k++) w = (w << 4) | 16'(msg_tbl[(p + k) % MSG_LEN]);
    return w;
  endfunction

  // Behavioural model: scrolling advances once per TICK_DIV cycles spent running.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = ST_IDLE; m_cnt = 0; m_pcnt = 0; m_pos = 0; m_wrap = 0;
        exp_q.delete();
      end else begin
        int  nxt_mode;
        int  nxt;
        bit  tick;
        bit  mv;
        m_wrap   = 0;
        nxt_mode = m_mode;
        tick     = (m_mode != ST_IDLE) && (m_cnt == TICK_DIV - 1);
        m_cnt    = (m_mode != ST_IDLE) ? (m_cnt + 1) % TICK_DIV : 0;
        mv       = 0;
        if (m_mode == ST_IDLE) begin
          mv = step;
          if (en) nxt_mode = ST_RUN;
        end else if (m_mode == ST_RUN) begin
          mv = tick || step;
          if (!en) nxt_mode = ST_IDLE;
        end else begin
          if (tick) begin
            m_pcnt++;
            if (m_pcnt == PAUSE_TICKS) begin
              mv = 1; nxt_mode = ST_RUN; m_pcnt = 0;
            end
          end
          if (!en) begin
            mv = 0; nxt_mode = ST_IDLE; m_pcnt = 0;
          end
        end
        if (mv) begin
          nxt    = dir ? m_pos - 1 : m_pos + 1;
          m_wrap = (nxt < 0 || nxt >= MSG_LEN) ? 1 : 0;
          m_pos  = (nxt + MSG_LEN) % MSG_LEN;
          exp_q.push_back(4'(m_pos));
        end
`ifdef MSG_SCROLLER_PAUSE_EN
        if (m_mode == ST_RUN && en && m_wrap == 1) begin
          nxt_mode = ST_PAUSE; m_cnt = 0; m_pcnt = 0;
        end
`endif
        if (nxt_mode == ST_IDLE) m_cnt = 0;
        m_mode = nxt_mode;
      end
    end
  end

  // Compare process: every falling edge
  initial begin
    logic [3:0] prev_pos;
    prev_pos = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_pos", pos_o, 0);
        check("rst_wrap", wrap_o, 0);
        check("rst_state", state_o, ST_IDLE);
        check("rst_digits", digits_o, 16'hAAC0);
      end else begin
        check("cyc_pos", pos_o, m_pos);
        check("cyc_wrap", wrap_o, m_wrap);
        check("cyc_state", state_o, m_mode);
        check("cyc_digits", digits_o, window(m_pos));
        if (pos_o !== prev_pos) begin
          if (exp_q.size() == 0) check("unexpected_move", pos_o, prev_pos);
          else check("move_seq", pos_o, exp_q.pop_front());
        end
      end
      prev_pos = pos_o;
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge
  task automatic drive(input logic r, input logic e, input logic d, input logic s);
    @(posedge clk);
    #2;
    rst_n = r; en = e; dir = d; step = s;
  endtask

  task automatic step_pulse();
    drive(rst_n, en, dir, 1'b1);
    drive(rst_n, en, dir, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_pos(input int target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos_o !== 4'(target) && n < budget);
    check(name, pos_o, target);
  endtask

  task automatic run_latency(input string name);
    int n;
    int lat;
    n = 0;
    while (state_o !== ST_RUN && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_run"}, state_o, ST_RUN);
    lat = 0;
    while (pos_o === 4'd0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_pos"}, pos_o, 1);
  endtask

  initial begin
    int p;
    int hold;
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digits", digits_o, 16'hAAC0);
    check("reset_pos", pos_o, 0);
    check("reset_wrap", wrap_o, 0);

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    run_latency("start");

    wait_pos(14, 100, "reach_14");
    check("digits_at_14", digits_o, 16'h0DAA);
    wait_pos(0, 20, "wrap_to_0");
    check("wrap_pulse_adv", wrap_o, 1);
    @(negedge clk);
    check("wrap_one_cycle", wrap_o, 0);

    drive(1'b1, 1'b1, 1'b1, 1'b0);
    wait_pos(15, 40, "reverse_to_15");
    check("wrap_pulse_rev", wrap_o, 1);
    check("digits_at_15", digits_o, 16'hDAAC);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_state", state_o, ST_IDLE);
    check("idle_hold_pos", pos_o, 15);
    step_pulse();
    check("step_1", pos_o, 0);
    step_pulse();
    check("step_2", pos_o, 1);
    step_pulse();
    check("step_3", pos_o, 2);
    repeat (8) @(negedge clk);
    check("idle_no_scroll", pos_o, 2);

    // Step aligned with the tick cycle must produce exactly one move.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    p = pos_o;
    hold = 0;
    do begin
      @(negedge clk);
      hold++;
    end while (pos_o == 4'(p) && hold < 20);
    p = pos_o;
    repeat (2) @(posedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("coincident_single_move", pos_o, (p + 1) % MSG_LEN);
    @(negedge clk);
    check("coincident_no_second", pos_o, (p + 1) % MSG_LEN);

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_mid_scroll_pos", pos_o, 0);
    check("reset_mid_scroll_state", state_o, ST_IDLE);
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    run_latency("restart");

`ifdef MSG_SCROLLER_PAUSE_EN
    wait_pos(15, 100, "pause_reach_15");
    wait_pos(0, 20, "pause_wrap");
    check("pause_entered", state_o, ST_PAUSE);
    hold = 1;
    while (hold < 60) begin
      @(posedge clk);
      #2;
      step = (hold < 10) ? 1'(hold % 2) : 1'b0;
      @(negedge clk);
      if (pos_o == 4'd0) hold++;
      else break;
    end
    step = 1'b0;
    check("pause_hold_cycles", hold, 16);
    check("pause_then_advance", pos_o, 1);

    wait_pos(15, 100, "pause2_reach_15");
    wait_pos(0, 20, "pause2_wrap");
    repeat (5) @(negedge clk);
    check("pause2_state", state_o, ST_PAUSE);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_mid_pause_state", state_o, ST_IDLE);
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    run_latency("pause_restart");
`endif

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
